// File: rtl/rot_pkg.sv
// Shared types and helpers for the rotate request stage.
package rot_pkg;

    localparam int DATA_W  = 64;
    localparam int SHAMT_W = 6;
    // Tag width lives here because the packed request struct needs a fixed width.
    localparam int TAG_W   = 4;

    typedef enum logic {ROT_RIGHT = 1'b0, ROT_LEFT = 1'b1} rot_dir_e;

    typedef enum logic [1:0] {FIFO_EMPTY, FIFO_ACTIVE, FIFO_FULL} fifo_state_e;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [SHAMT_W-1:0] amt_eff;
        logic [TAG_W-1:0]   tag;
    } rot_req_t;

    // Rotate left by n equals rotate right by (DATA_W - n) mod DATA_W. DATA_W is
    // 2**SHAMT_W, so the modulo is simply truncation to SHAMT_W bits.
    function automatic logic [SHAMT_W-1:0] to_ror_amt(input logic [SHAMT_W-1:0] amt,
                                                     input rot_dir_e         dir);
        logic [SHAMT_W-1:0] neg_amt;
        neg_amt = SHAMT_W'(DATA_W) - amt;
        return (dir == ROT_LEFT) ? neg_amt : amt;
    endfunction

endpackage

// File: rtl/rot_req_fifo.sv
// DEPTH-entry request FIFO; accepts a push while full when a pop happens the same cycle.
module rot_req_fifo
    import rot_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  logic     pop,
    input  rot_req_t wr_req,
    output rot_req_t head,
    output logic     empty,
    output logic     full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    rot_req_t           mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    fifo_state_e        state;
    logic               do_push;
    logic               do_pop;

    assign do_pop  = pop && (state != FIFO_EMPTY);
    assign do_push = push && ((state != FIFO_FULL) || do_pop);

    assign empty = (state == FIFO_EMPTY);
    assign full  = (state == FIFO_FULL);
    assign head  = mem[rd_ptr];

    // Storage write; pointers wrap naturally because DEPTH is a power of two.
    // NOTE: the entry array is not reset -- occupancy is tracked by count/state, so stale data is never observed.
    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            mem[wr_ptr] <= wr_req;
        end
    end

    // Pointers, occupancy count and the EMPTY/ACTIVE/FULL state.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            state  <= FIFO_EMPTY;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10: begin
                    count <= count + 1'b1;
                    state <= (count == CNT_W'(DEPTH - 1)) ? FIFO_FULL : FIFO_ACTIVE;
                end
                2'b01: begin
                    count <= count - 1'b1;
                    state <= (count == CNT_W'(1)) ? FIFO_EMPTY : FIFO_ACTIVE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/rot_issue_stage.sv
// Request-side stage in front of the 64-bit rotate-right shifter: buffers requests,
// converts rotate-left to rotate-right, feeds the shifter from the FIFO head and
// registers the result into a valid/ready response slot.
// Optional: define ROT_PERF_CNT_EN to add the cnt_ops / cnt_stall counters.
module rot_issue_stage
    import rot_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [DATA_W-1:0]  req_data,
    input  logic [SHAMT_W-1:0] req_amt,
    input  logic               req_dir,
    input  logic [TAG_W-1:0]   req_tag,
    output logic [DATA_W-1:0]  sh_in,
    output logic [SHAMT_W-1:0] sh_amt,
    input  logic [DATA_W-1:0]  sh_result,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_data,
    output logic [TAG_W-1:0]   rsp_tag
`ifdef ROT_PERF_CNT_EN
    ,
    output logic [31:0]        cnt_ops,
    output logic [31:0]        cnt_stall
`endif
);

    rot_req_t wr_req;
    rot_req_t head;
    logic     empty;
    logic     full;
    logic     push;
    logic     pop;

    // Capture whenever there is a head entry and the response slot is free or draining.
    assign pop       = !empty && (!rsp_valid || rsp_ready);
    assign req_ready = rst_n && (!full || pop);
    assign push      = req_valid && req_ready;

    // Only the effective rotate-right amount is stored; direction is dropped here.
    assign wr_req = '{data:    req_data,
                      amt_eff: to_ror_amt(req_amt, rot_dir_e'(req_dir)),
                      tag:     req_tag};

    rot_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push),
        .pop    (pop),
        .wr_req (wr_req),
        .head   (head),
        .empty  (empty),
        .full   (full)
    );

    assign sh_in  = head.data;
    assign sh_amt = head.amt_eff;

    // Response slot: capture the shifter output on pop, otherwise drain on rsp_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_tag   <= '0;
        end else if (pop) begin
            rsp_valid <= 1'b1;
            rsp_data  <= sh_result;
            rsp_tag   <= head.tag;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef ROT_PERF_CNT_EN
    // Free-running 32-bit performance counters; wrap at 2**32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_ops   <= '0;
            cnt_stall <= '0;
        end else begin
            if (rsp_valid && rsp_ready)  cnt_ops   <= cnt_ops + 32'd1;
            if (req_valid && !req_ready) cnt_stall <= cnt_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rot_issue_stage.sv
// Self-checking bench for rot_issue_stage: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a queue-based model.
module tb_rot_issue_stage;
    import rot_pkg::*;

    localparam int DEPTH = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               req_valid;
    logic               req_ready;
    logic [DATA_W-1:0]  req_data;
    logic [SHAMT_W-1:0] req_amt;
    logic               req_dir;
    logic [TAG_W-1:0]   req_tag;
    logic [DATA_W-1:0]  sh_in;
    logic [SHAMT_W-1:0] sh_amt;
    logic [DATA_W-1:0]  sh_result;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [DATA_W-1:0]  rsp_data;
    logic [TAG_W-1:0]   rsp_tag;
`ifdef ROT_PERF_CNT_EN
    logic [31:0]        cnt_ops;
    logic [31:0]        cnt_stall;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Stand-in for the external combinational rotate-right shifter.
    assign sh_result = DATA_W'({sh_in, sh_in} >> sh_amt);

    rot_issue_stage #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_amt   (req_amt),
        .req_dir   (req_dir),
        .req_tag   (req_tag),
        .sh_in     (sh_in),
        .sh_amt    (sh_amt),
        .sh_result (sh_result),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_tag   (rsp_tag)
`ifdef ROT_PERF_CNT_EN
        ,
        .cnt_ops   (cnt_ops),
        .cnt_stall (cnt_stall)
`endif
    );

    typedef struct {
        logic [63:0] data;
        logic [5:0]  amt;
        logic        dir;
        logic [3:0]  tag;
        logic [5:0]  exp_amt;
        logic [63:0] exp_data;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  tag;
    } exp_t;

    vec_t vecs[10];
    exp_t model_q[$];
    exp_t slot;
    logic [63:0] gold[16];

    // Bit-wise rotate: left moves bit i to i+amt, right takes bit i from i+amt.
    function automatic logic [63:0] ref_rotate(input logic [63:0] d, input int amt, input bit left);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            if (left) r[(i + amt) % 64] = d[i];
            else      r[i] = d[(i + amt) % 64];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] d, input logic [5:0] a, input logic dir, input logic [3:0] t);
        req_valid = 1'b1;
        req_data  = d;
        req_amt   = a;
        req_dir   = dir;
        req_tag   = t;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        logic        pop_m;
        logic        exp_ready;
        logic        slot_v;
        logic [63:0] d;

        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_data  = 64'hDEAD_BEEF_0000_0001;
        req_amt   = '0;
        req_dir   = 1'b0;
        req_tag   = '0;
        rsp_ready = 1'b1;

        vecs[0] = '{64'h0000_0000_0000_0001, 6'd1,  1'b0, 4'h1, 6'd1,  64'h8000_0000_0000_0000};
        vecs[1] = '{64'h8000_0000_0000_0001, 6'd4,  1'b1, 4'h2, 6'd60, 64'h0000_0000_0000_0018};
        vecs[2] = '{64'h0123_4567_89AB_CDEF, 6'd0,  1'b1, 4'h3, 6'd0,  64'h0123_4567_89AB_CDEF};
        vecs[3] = '{64'h0123_4567_89AB_CDEF, 6'd0,  1'b0, 4'h4, 6'd0,  64'h0123_4567_89AB_CDEF};
        vecs[4] = '{64'h0123_4567_89AB_CDEF, 6'd4,  1'b0, 4'h5, 6'd4,  64'hF012_3456_789A_BCDE};
        vecs[5] = '{64'h0123_4567_89AB_CDEF, 6'd4,  1'b1, 4'h6, 6'd60, 64'h1234_5678_9ABC_DEF0};
        vecs[6] = '{64'h0123_4567_89AB_CDEF, 6'd32, 1'b0, 4'h7, 6'd32, 64'h89AB_CDEF_0123_4567};
        vecs[7] = '{64'h8000_0000_0000_0000, 6'd1,  1'b1, 4'h8, 6'd63, 64'h0000_0000_0000_0001};
        vecs[8] = '{64'h0000_0000_0000_0001, 6'd63, 1'b0, 4'h9, 6'd63, 64'h0000_0000_0000_0002};
        vecs[9] = '{64'h0000_0000_0000_0001, 6'd63, 1'b1, 4'hA, 6'd1,  64'h8000_0000_0000_0000};

        // Reset state, with a request pending to show req_ready stays low.
        step();
        step();
        check("reset_req_ready", 64'(req_ready), 64'd0);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_data", rsp_data, 64'd0);
        check("reset_rsp_tag", 64'(rsp_tag), 64'd0);
`ifdef ROT_PERF_CNT_EN
        check("reset_cnt_ops", 64'(cnt_ops), 64'd0);
        check("reset_cnt_stall", 64'(cnt_stall), 64'd0);
`endif
        req_valid = 1'b0;
        rst_n     = 1'b1;
        step();

        // Directed vector table: single request each, latency and result.
        rsp_ready = 1'b1;
        for (int v = 0; v < 10; v++) begin
            send(vecs[v].data, vecs[v].amt, vecs[v].dir, vecs[v].tag);
            #1;
            check($sformatf("vec%0d_req_ready", v), 64'(req_ready), 64'd1);
            step();
            req_valid = 1'b0;
            #1;
            check($sformatf("vec%0d_rsp_valid_early", v), 64'(rsp_valid), 64'd0);
            check($sformatf("vec%0d_sh_amt", v), 64'(sh_amt), 64'(vecs[v].exp_amt));
            check($sformatf("vec%0d_sh_in", v), sh_in, vecs[v].data);
            step();
            check($sformatf("vec%0d_rsp_valid", v), 64'(rsp_valid), 64'd1);
            check($sformatf("vec%0d_rsp_data", v), rsp_data, vecs[v].exp_data);
            check($sformatf("vec%0d_rsp_tag", v), 64'(rsp_tag), 64'(vecs[v].tag));
            step();
            check($sformatf("vec%0d_rsp_drained", v), 64'(rsp_valid), 64'd0);
        end

`ifdef ROT_PERF_CNT_EN
        // Counters: 5 ops and 3 blocked cycles from a clean reset.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(64'(i + 1), 6'd0, 1'b0, 4'(i));
            step();
        end
        send(64'h55, 6'd0, 1'b0, 4'hF);
        step();
        step();
        step();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        step();
        step();
        send(64'h66, 6'd1, 1'b0, 4'h4);
        step();
        send(64'h77, 6'd1, 1'b0, 4'h5);
        step();
        req_valid = 1'b0;
        step();
        step();
        step();
        check("perf_cnt_ops", 64'(cnt_ops), 64'd5);
        check("perf_cnt_stall", 64'(cnt_stall), 64'd3);
`endif

        // Backpressure: three requests fill FIFO plus response slot.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(64'h1000 + 64'(i), 6'd4, 1'b0, 4'(i));
            #1;
            check($sformatf("bp_accept%0d", i), 64'(req_ready), 64'd1);
            step();
        end
        req_valid = 1'b0;
        #1;
        check("bp_full_req_ready", 64'(req_ready), 64'd0);
        check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        check("bp_rsp_tag0", 64'(rsp_tag), 64'd0);
        d = rsp_data;
        step();
        step();
        check("bp_hold_data", rsp_data, d);
        check("bp_hold_tag", 64'(rsp_tag), 64'd0);
        rsp_ready = 1'b1;
        #1;
        check("bp_pop_through_ready", 64'(req_ready), 64'd1);
        check("bp_rsp_data0", rsp_data, ref_rotate(64'h1000, 4, 1'b0));
        step();
        check("bp_rsp_tag1", 64'(rsp_tag), 64'd1);
        check("bp_rsp_data1", rsp_data, ref_rotate(64'h1001, 4, 1'b0));
        step();
        check("bp_rsp_tag2", 64'(rsp_tag), 64'd2);
        check("bp_rsp_valid2", 64'(rsp_valid), 64'd1);
        step();
        check("bp_drained", 64'(rsp_valid), 64'd0);

        // Streaming: 16 back-to-back requests, one response per cycle.
        for (int i = 0; i < 17; i++) begin
            if (i < 16) begin
                d = {$urandom, $urandom};
                gold[i] = ref_rotate(d, i, 1'b0);
                send(d, 6'(i), 1'b0, 4'(i));
                #1;
                check($sformatf("stream_ready%0d", i), 64'(req_ready), 64'd1);
            end else begin
                req_valid = 1'b0;
            end
            step();
            if (i >= 1) begin
                check($sformatf("stream_valid%0d", i - 1), 64'(rsp_valid), 64'd1);
                check($sformatf("stream_data%0d", i - 1), rsp_data, gold[i-1]);
                check($sformatf("stream_tag%0d", i - 1), 64'(rsp_tag), 64'(i - 1));
            end
        end
        step();
        check("stream_drained", 64'(rsp_valid), 64'd0);

        // Reset mid-run with requests queued and a response held.
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(64'hABC0 + 64'(i), 6'd8, 1'b1, 4'(5 + i));
            step();
        end
        req_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("midrst_req_ready_low", 64'(req_ready), 64'd0);
        step();
        rst_n = 1'b1;
        #1;
        check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("midrst_rsp_data", rsp_data, 64'd0);
        check("midrst_rsp_tag", 64'(rsp_tag), 64'd0);
        check("midrst_req_ready", 64'(req_ready), 64'd1);
        rsp_ready = 1'b1;
        send(64'h0123_4567_89AB_CDEF, 6'd8, 1'b0, 4'h9);
        step();
        req_valid = 1'b0;
        #1;
        check("midrst_no_stale", 64'(rsp_valid), 64'd0);
        step();
        check("midrst_next_valid", 64'(rsp_valid), 64'd1);
        check("midrst_next_data", rsp_data, 64'hEF01_2345_6789_ABCD);
        check("midrst_next_tag", 64'(rsp_tag), 64'h9);
        step();
        check("midrst_next_drained", 64'(rsp_valid), 64'd0);

        // Randomized traffic against a queue model of FIFO plus response slot.
        do_reset();
        slot_v = 1'b0;
        slot   = '{64'd0, 4'd0};
        model_q.delete();
        for (int c = 0; c < 406; c++) begin
            if (c < 400) begin
                req_valid = ($urandom_range(0, 3) != 0);
                req_data  = {$urandom, $urandom};
                req_amt   = SHAMT_W'($urandom);
                req_dir   = 1'($urandom);
                req_tag   = TAG_W'($urandom);
                rsp_ready = ($urandom_range(0, 2) != 0);
            end else begin
                req_valid = 1'b0;
                rsp_ready = 1'b1;
            end
            #1;
            pop_m     = (model_q.size() > 0) && (!slot_v || rsp_ready);
            exp_ready = (model_q.size() < DEPTH) || pop_m;
            check("rand_req_ready", 64'(req_ready), 64'(exp_ready));
            check("rand_rsp_valid", 64'(rsp_valid), 64'(slot_v));
            if (slot_v) begin
                check("rand_rsp_data", rsp_data, slot.data);
                check("rand_rsp_tag", 64'(rsp_tag), 64'(slot.tag));
            end
            if (pop_m) begin
                slot   = model_q.pop_front();
                slot_v = 1'b1;
            end else if (rsp_ready) begin
                slot_v = 1'b0;
            end
            if (req_valid && exp_ready) begin
                model_q.push_back('{ref_rotate(req_data, int'(req_amt), req_dir), req_tag});
            end
            step();
        end
        check("rand_final_valid", 64'(rsp_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
